// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI register-write initiator.
//   - frame field positions of the 16-bit write frame (R/W, address, data)
//   - register addresses decoded by the spi_peripheral
//   - controller state enum
//   - small helper used to size the phase timer
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] MAX_ADDRESS      = 7'h04;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } ctrl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter with terminal-count flag.
// Ports:
//   clk, rst      system clock, async active-high reset
//   i_load        load i_load_val this cycle (a phase of N cycles loads N-1)
//   i_load_val    reload value
//   o_tc          count has reached zero (holds at zero until reloaded)
module spi_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 write initiator producing the 16-bit
// {R/W, addr[6:0], data[7:0]} frame, MSB first, for spi_peripheral.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_rw, req_addr, req_data  frame contents, captured on accept
//   busy                     high in every state except IDLE
//   done                     one-cycle pulse on the first IDLE cycle after a frame
//   sclk, mosi, cs_n         SPI pins, all registered
//
// state   | meaning
// IDLE    | cs_n high, waiting for a request
// SETUP   | cs_n low, first bit on mosi, CS_SETUP cycles
// SCLK_HI | sclk high for CLK_DIV cycles, mosi stable
// SCLK_LO | sclk low for CLK_DIV cycles, mosi advanced on entry
// HOLD    | cs_n low, sclk low, mosi 0 for CS_HOLD cycles
// GAP     | cs_n high for CS_GAP cycles before returning to IDLE
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n
);

  if (CLK_DIV < 3) begin : g_chk_div
    $error("spi_controller: CLK_DIV must be >= 3");
  end
  if (CS_SETUP < 1) begin : g_chk_setup
    $error("spi_controller: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_chk_hold
    $error("spi_controller: CS_HOLD must be >= 1");
  end
  if (CS_GAP < 4) begin : g_chk_gap
    $error("spi_controller: CS_GAP must be >= 4");
  end

  localparam int TMAX = max_int(max_int(CLK_DIV, CS_SETUP), max_int(CS_HOLD, CS_GAP));
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] LD_DIV   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LD_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] LD_GAP   = TW'(CS_GAP - 1);

  ctrl_state_t           r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic                  w_load;
  logic [TW-1:0]         w_load_val;
  logic                  w_tc;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_cs_n_nxt, w_sclk_nxt, w_mosi_nxt;
  logic                  r_cs_n, r_sclk, r_mosi, r_busy, r_done, r_ready;

  spi_phase_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_frame                    = '0;
    w_frame[RW_BIT]            = req_rw;
    w_frame[ADDR_MSB:ADDR_LSB] = req_addr;
    w_frame[DATA_MSB:0]        = req_data;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_load        = 1'b0;
    w_load_val    = '0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_shift_nxt   = w_frame;
          w_bit_cnt_nxt = '0;
          w_load        = 1'b1;
          w_load_val    = LD_SETUP;
          w_state_nxt   = SETUP;
        end
      end
      SETUP: begin
        if (w_tc) begin
          w_load      = 1'b1;
          w_load_val  = LD_DIV;
          w_state_nxt = SCLK_HI;
        end
      end
      SCLK_HI: begin
        if (w_tc) begin
          w_load        = 1'b1;
          w_load_val    = LD_DIV;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          // after the last bit there is nothing to advance; mosi keeps bit 0
          if (r_bit_cnt != 4'd15) begin
            w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
          end
          w_state_nxt = SCLK_LO;
        end
      end
      SCLK_LO: begin
        if (w_tc) begin
          w_load = 1'b1;
          // the 4-bit counter wraps to zero once all 16 HI phases are done
          if (r_bit_cnt == 4'd0) begin
            w_load_val  = LD_HOLD;
            w_state_nxt = HOLD;
          end else begin
            w_load_val  = LD_DIV;
            w_state_nxt = SCLK_HI;
          end
        end
      end
      HOLD: begin
        if (w_tc) begin
          w_load      = 1'b1;
          w_load_val  = LD_GAP;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_tc) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // pin values are decoded from the next state and registered, so the pins
  // track the state register with no combinational path from the inputs
  always_comb begin
    w_cs_n_nxt = (w_state_nxt == IDLE) || (w_state_nxt == GAP);
    w_sclk_nxt = (w_state_nxt == SCLK_HI);
    w_mosi_nxt = 1'b0;
    if ((w_state_nxt == SETUP) || (w_state_nxt == SCLK_HI) || (w_state_nxt == SCLK_LO)) begin
      w_mosi_nxt = w_shift_nxt[RW_BIT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (r_state == GAP) && (w_state_nxt == IDLE);
      r_ready   <= (w_state_nxt == IDLE);
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign cs_n      = r_cs_n;

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default-parameter instance
  logic       a_valid = 1'b0, a_rw = 1'b0;
  logic [6:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       a_ready, a_busy, a_done, a_sclk, a_mosi, a_cs_n;

  // CLK_DIV=3 instance
  logic       b_valid = 1'b0, b_rw = 1'b0;
  logic [6:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_busy, b_done, b_sclk, b_mosi, b_cs_n;

  spi_controller dut (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_rw(a_rw), .req_addr(a_addr), .req_data(a_data),
    .busy(a_busy), .done(a_done), .sclk(a_sclk), .mosi(a_mosi), .cs_n(a_cs_n)
  );

  spi_controller #(.CLK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_rw(b_rw), .req_addr(b_addr), .req_data(b_data),
    .busy(b_busy), .done(b_done), .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_cs_n)
  );

  // Pin-level peripheral model for each instance: shifts mosi on sclk rise
  // while selected, commits a complete 16-bit write frame on cs_n rise.
  logic [7:0]  per_regs [0:4];
  logic [7:0]  exp_regs [0:4];
  logic [7:0]  b_regs   [0:4];
  logic        a_sclk_q = 1'b0, a_mosi_q = 1'b0, a_cs_q = 1'b1;
  logic [15:0] a_sh = '0, a_last_frame = '0;
  int          a_rises = 0, a_cs_low = 0, a_cs_high = 0, a_last_low = 0;
  int          a_last_rises = 0, a_frames = 0, a_min_gap = 1000, a_viol = 0;
  logic        b_sclk_q = 1'b0, b_mosi_q = 1'b0, b_cs_q = 1'b1;
  logic [15:0] b_sh = '0, b_last_frame = '0;
  int          b_rises = 0, b_cs_low = 0, b_last_low = 0, b_last_rises = 0, b_viol = 0;

  initial begin
    for (int i = 0; i < 5; i++) begin
      per_regs[i] = '0;
      exp_regs[i] = '0;
      b_regs[i]   = '0;
    end
  end

  always @(negedge clk) begin
    if (a_sclk && a_sclk_q && (a_mosi !== a_mosi_q)) a_viol++;
    if (a_cs_n && a_cs_q && (a_sclk !== a_sclk_q)) a_viol++;
    if (!a_cs_n) begin
      a_cs_low++;
      if (a_sclk && !a_sclk_q) begin
        a_sh = {a_sh[14:0], a_mosi};
        a_rises++;
      end
    end
    if (a_cs_n && !a_cs_q) begin
      a_last_low   = a_cs_low;
      a_last_rises = a_rises;
      a_last_frame = a_sh;
      a_frames++;
      if (a_rises == 16 && a_sh[15] && a_sh[14:8] <= MAX_ADDRESS)
        per_regs[int'(a_sh[14:8])] = a_sh[7:0];
      a_cs_low  = 0;
      a_rises   = 0;
      a_cs_high = 0;
    end
    if (!a_cs_n && a_cs_q && a_cs_high < a_min_gap) a_min_gap = a_cs_high;
    if (a_cs_n) a_cs_high++;
    a_sclk_q = a_sclk; a_mosi_q = a_mosi; a_cs_q = a_cs_n;

    if (b_sclk && b_sclk_q && (b_mosi !== b_mosi_q)) b_viol++;
    if (b_cs_n && b_cs_q && (b_sclk !== b_sclk_q)) b_viol++;
    if (!b_cs_n) begin
      b_cs_low++;
      if (b_sclk && !b_sclk_q) begin
        b_sh = {b_sh[14:0], b_mosi};
        b_rises++;
      end
    end
    if (b_cs_n && !b_cs_q) begin
      b_last_low   = b_cs_low;
      b_last_rises = b_rises;
      b_last_frame = b_sh;
      if (b_rises == 16 && b_sh[15] && b_sh[14:8] <= MAX_ADDRESS)
        b_regs[int'(b_sh[14:8])] = b_sh[7:0];
      b_cs_low = 0;
      b_rises  = 0;
    end
    b_sclk_q = b_sclk; b_mosi_q = b_mosi; b_cs_q = b_cs_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present a request on the default instance; c0 is the accept cycle.
  task automatic start_req(input logic rw, input logic [6:0] ad, input logic [7:0] d,
                           output int c0);
    int w;
    w = 0;
    a_valid = 1'b1; a_rw = rw; a_addr = ad; a_data = d;
    while (!a_ready && w < 400) begin tick(); w++; end
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait ready=%b required=1", a_ready);
    end
    c0 = cyc;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic wait_done(output int cd);
    int w;
    w = 0;
    while (a_done !== 1'b1 && w < 1000) begin tick(); w++; end
    cd = (a_done === 1'b1) ? cyc : -1;
  endtask

  function automatic logic [15:0] frame_of(input logic rw, input logic [6:0] ad,
                                           input logic [7:0] d);
    return {rw, ad, d};
  endfunction

  // model of the register file: only in-range writes land
  function automatic void model_write(input logic rw, input logic [6:0] ad, input logic [7:0] d);
    if (rw && ad <= MAX_ADDRESS) exp_regs[int'(ad)] = d;
  endfunction

  task automatic check_regs(input string name);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (per_regs[i] !== exp_regs[i]) begin
        bad++;
        $display("FAIL %s reg%0d got=%h exp=%h", name, i, per_regs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    obs = {a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_ready};
    total++;
    if (obs !== 6'b100_001) begin
      bad++;
      $display("FAIL reset_pins {cs_n,sclk,mosi,busy,done,ready} got=%b exp=100001", obs);
    end
    rst = 1'b0;
    tick(); tick();
    obs = {a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_ready};
    total++;
    if (obs !== 6'b100_001) begin
      bad++;
      $display("FAIL idle_pins got=%b exp=100001", obs);
    end
  endtask

  task automatic test_write_pwm();
    int c0, cd;
    start_req(1'b1, ADDR_PWM_DUTY, 8'hA5, c0);
    total++;
    if (a_busy !== 1'b1 || a_cs_n !== 1'b0) begin
      bad++;
      $display("FAIL pwm_busy busy=%b cs_n=%b exp busy=1 cs_n=0", a_busy, a_cs_n);
    end
    model_write(1'b1, ADDR_PWM_DUTY, 8'hA5);
    wait_done(cd);
    total++;
    if (cd - c0 !== 145) begin
      bad++;
      $display("FAIL pwm_latency got=%0d exp=145", cd - c0);
    end
    total++;
    if (a_last_frame !== 16'h84A5) begin
      bad++;
      $display("FAIL pwm_frame got=%h exp=84a5", a_last_frame);
    end
    total++;
    if (a_last_rises !== 16) begin
      bad++;
      $display("FAIL pwm_rises got=%0d exp=16", a_last_rises);
    end
    total++;
    if (a_last_low !== 136) begin
      bad++;
      $display("FAIL pwm_cs_low got=%0d exp=136", a_last_low);
    end
    total++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL pwm_done_cycle ready=%b busy=%b exp 1 0", a_ready, a_busy);
    end
    tick();
    total++;
    if (a_done !== 1'b0) begin
      bad++;
      $display("FAIL pwm_done_width done=%b exp=0", a_done);
    end
    check_regs("pwm_regs");
  endtask

  task automatic test_back_to_back();
    int f0, w, on_done, cd;
    f0 = a_frames;
    a_min_gap = 1000;
    on_done = 0;
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_rw = 1'b1; a_addr = 7'(i); a_data = 8'((i + 1) * 8'h11);
      w = 0;
      while (!a_ready && w < 400) begin tick(); w++; end
      if (a_done === 1'b1) on_done++;
      model_write(1'b1, 7'(i), 8'((i + 1) * 8'h11));
      tick();
    end
    a_valid = 1'b0;
    wait_done(cd);
    total++;
    if (cd < 0 || a_frames - f0 !== 5) begin
      bad++;
      $display("FAIL b2b_frames got=%0d exp=5", a_frames - f0);
    end
    total++;
    if (on_done !== 4) begin
      bad++;
      $display("FAIL b2b_accept_on_done got=%0d exp=4", on_done);
    end
    total++;
    if (a_min_gap < 9) begin
      bad++;
      $display("FAIL b2b_gap got=%0d exp>=9", a_min_gap);
    end
    check_regs("b2b_regs");
  endtask

  task automatic test_read();
    int c0, cd;
    start_req(1'b0, ADDR_EN_PWM_7_0, 8'hFF, c0);
    model_write(1'b0, ADDR_EN_PWM_7_0, 8'hFF);
    wait_done(cd);
    total++;
    if (cd - c0 !== 145) begin
      bad++;
      $display("FAIL read_latency got=%0d exp=145", cd - c0);
    end
    total++;
    if (a_last_frame !== 16'h02FF) begin
      bad++;
      $display("FAIL read_frame got=%h exp=02ff", a_last_frame);
    end
    total++;
    if (per_regs[2] !== 8'h33) begin
      bad++;
      $display("FAIL read_pwm7_0 got=%h exp=33", per_regs[2]);
    end
  endtask

  task automatic test_out_of_range();
    int c0, cd;
    start_req(1'b1, 7'h10, 8'h7E, c0);
    model_write(1'b1, 7'h10, 8'h7E);
    wait_done(cd);
    total++;
    if (cd < 0 || a_last_frame !== 16'h907E) begin
      bad++;
      $display("FAIL oor_frame got=%h exp=907e", a_last_frame);
    end
    check_regs("oor_regs");
  endtask

  task automatic test_reset_mid();
    int c0, cd, w, seen_done;
    start_req(1'b1, ADDR_EN_OUT_7_0, 8'hC3, c0);
    w = 0;
    while (a_rises < 7 && w < 300) begin tick(); w++; end
    total++;
    if (a_rises !== 7) begin
      bad++;
      $display("FAIL mid_reach_7 rises=%0d exp=7", a_rises);
    end
    rst = 1'b1;
    #1;
    total++;
    if (a_cs_n !== 1'b1 || a_sclk !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_async cs_n=%b sclk=%b busy=%b exp 1 0 0", a_cs_n, a_sclk, a_busy);
    end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_done !== 1'b0) seen_done++;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_done !== 1'b0) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL mid_no_done got=%0d exp=0", seen_done);
    end
    total++;
    if (a_last_rises !== 7) begin
      bad++;
      $display("FAIL mid_partial_rises got=%0d exp=7", a_last_rises);
    end
    total++;
    if (per_regs[0] !== exp_regs[0]) begin
      bad++;
      $display("FAIL mid_reg0_kept got=%h exp=%h", per_regs[0], exp_regs[0]);
    end
    start_req(1'b1, ADDR_EN_OUT_7_0, 8'h3C, c0);
    model_write(1'b1, ADDR_EN_OUT_7_0, 8'h3C);
    wait_done(cd);
    total++;
    if (cd - c0 !== 145 || per_regs[0] !== 8'h3C) begin
      bad++;
      $display("FAIL mid_rewrite lat=%0d reg0=%h exp 145 3c", cd - c0, per_regs[0]);
    end
  endtask

  task automatic test_random();
    int c0, cd;
    logic       rw;
    logic [6:0] ad;
    logic [7:0] d;
    for (int n = 0; n < 8; n++) begin
      rw = ($urandom_range(0, 3) != 0);
      ad = 7'($urandom_range(0, 7));
      d  = 8'($urandom);
      start_req(rw, ad, d, c0);
      model_write(rw, ad, d);
      wait_done(cd);
      total++;
      if (cd - c0 !== 145 || a_last_frame !== frame_of(rw, ad, d)) begin
        bad++;
        $display("FAIL rand%0d lat=%0d frame=%h exp 145 %h", n, cd - c0, a_last_frame,
                 frame_of(rw, ad, d));
      end
      check_regs("rand_regs");
    end
    total++;
    if (a_viol !== 0) begin
      bad++;
      $display("FAIL stability_div4 violations=%0d exp=0", a_viol);
    end
  endtask

  task automatic test_clkdiv3();
    int c0, cd, w;
    b_valid = 1'b1; b_rw = 1'b1; b_addr = ADDR_EN_OUT_15_8; b_data = 8'h96;
    w = 0;
    while (!b_ready && w < 100) begin tick(); w++; end
    c0 = cyc;
    tick();
    b_valid = 1'b0;
    w = 0;
    while (b_done !== 1'b1 && w < 1000) begin tick(); w++; end
    cd = (b_done === 1'b1) ? cyc : -1;
    total++;
    if (cd - c0 !== 113) begin
      bad++;
      $display("FAIL div3_latency got=%0d exp=113", cd - c0);
    end
    total++;
    if (b_last_frame !== 16'h8196 || b_last_rises !== 16 || b_last_low !== 104) begin
      bad++;
      $display("FAIL div3_frame frame=%h rises=%0d low=%0d exp 8196 16 104",
               b_last_frame, b_last_rises, b_last_low);
    end
    total++;
    if (b_viol !== 0) begin
      bad++;
      $display("FAIL div3_stability violations=%0d exp=0", b_viol);
    end
    total++;
    if (b_regs[1] !== 8'h96) begin
      bad++;
      $display("FAIL div3_reg1 got=%h exp=96", b_regs[1]);
    end
  endtask

  initial begin
    tick(); tick();
    test_reset();
    test_write_pwm();
    test_back_to_back();
    test_read();
    test_out_of_range();
    test_reset_mid();
    test_random();
    test_clkdiv3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI Mode-0 write initiator that drives the 16-bit register-write frame consumed by our spi_peripheral. Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data, sent MSB first. Used in the testbench harness and by on-chip sequencers to program the enable and PWM registers over the pins. SCLK is derived from clk by an integer divider, slow enough for the peripheral's 2-FF synchronisers.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 3 for the peripheral's synchroniser.
CS_SETUP, 4, clk cycles from cs_n falling to the first SCLK rise; must be >= 1.
CS_HOLD, 4, clk cycles from the last SCLK fall to cs_n rising; must be >= 1.
CS_GAP, 8, minimum clk cycles cs_n stays high before the next frame; must be >= 4 so the peripheral commits.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller idle; request accepted when req_valid & req_ready
req_rw  input  1  frame bit15 (1 = write)
req_addr  input  7  frame bits14:8
req_data  input  8  frame bits7:0
busy  output  1  frame in progress (high in every state except IDLE)
done  output  1  one-cycle pulse at frame completion
sclk  output  1  SPI clock, idles low
mosi  output  1  SPI data
cs_n  output  1  chip select, active low

Behaviour:
- Reset (asynchronous, immediate): state IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, req_ready=1, shift register and counters cleared.
- All SPI outputs are registered; there are no combinational paths from inputs to pins.
- IDLE: req_ready=1. On req_valid & req_ready, capture {req_rw, req_addr, req_data} into a 16-bit shift register, then go to SETUP. Request inputs are ignored at all other times.
- SETUP: cs_n=0, sclk=0, mosi=frame[15]. Lasts CS_SETUP cycles, then go to SCLK_HI.
- SCLK_HI: sclk=1 for CLK_DIV cycles. mosi is held stable, so the peripheral samples on the rising edge.
- SCLK_LO: sclk=0 for CLK_DIV cycles.
  - On entry, if bits remain, shift so that mosi = the next bit. mosi changes only on SCLK falling, never while sclk=1.
  - A 4-bit bit counter increments per completed HI phase.
  - After the LO phase of bit 15, go to HOLD; otherwise return to SCLK_HI.
- HOLD: sclk=0, cs_n=0, mosi=0 for CS_HOLD cycles, then cs_n=1 and go to GAP.
- GAP: cs_n=1 for CS_GAP cycles, then go to IDLE. done pulses high for exactly the first IDLE cycle, together with req_ready=1.
- Exactly 16 SCLK rising edges per frame.
- cs_n low duration = CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (136 at defaults).
- Accept to done = 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD + CS_GAP cycles (145 at defaults).
- Back-to-back: req_valid held high is accepted on the done cycle. The next cs_n fall occurs the cycle after, so the cs_n-high gap is >= CS_GAP + 1.
- Reset mid-frame: cs_n returns high with fewer than 16 edges, and the peripheral discards the partial frame. No done pulse.
- Parameter violations are caught by elaboration-time checks (error on CLK_DIV<3, CS_SETUP/CS_HOLD<1, CS_GAP<4).
- Phase timer width is sized from max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP).

Decomposition:
- Shared package spi_pkg:
  - frame field positions (RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7).
  - register address constants ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04, MAX_ADDRESS=0x04.
  - controller state enum {IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP}.
- One sub-module, spi_phase_timer: loadable down-counter with a terminal-count flag, reused for every timed state.

Test Plan:
- Write 0x04 / 0xA5 (req_rw=1): the 16 mosi bits sampled at sclk rises are 0x84A5. cs_n is low for 136 cycles, done arrives at cycle 145 after accept, and the connected spi_peripheral's pwm_duty_cycle becomes 0xA5.
- Five back-to-back writes to addresses 0x00–0x04 with data 0x11, 0x22, 0x33, 0x44, 0x55 and req_valid held high: all five are accepted, each cs_n-high gap is >= 9 cycles, and the peripheral registers hold 0x11, 0x22, 0x33, 0x44, 0x55.
- Read frame (req_rw=0, addr 0x02, data 0xFF): 0x02FF is shifted out and done pulses, while en_reg_pwm_7_0 stays at its prior value.
- Out-of-range write (addr 0x10, data 0x7E): 0x907E is shifted out and no peripheral register changes.
- rst asserted after the 7th sclk rise of a write to 0x00 with data 0xC3: cs_n goes high and sclk low immediately, with no done pulse. en_reg_out_7_0 is unchanged, and a following write to 0x00 with data 0x3C lands correctly.
- Stability check with CLK_DIV=3: mosi never toggles while sclk=1, sclk never toggles while cs_n=1, and a write to 0x01 with data 0x96 succeeds.
